cla_serial_subtractor: RTL and testbench



---
 rtl/cla_serial_subtractor_pkg.sv | 12 +
 rtl/cla4_slice.sv | 33 +++
 rtl/cla_serial_subtractor.sv | 105 ++++++++++
 tb/tb_cla_serial_subtractor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cla_serial_subtractor_pkg.sv
// Shared types for the serial carry-lookahead subtractor: slice width and FSM states.
package cla_serial_subtractor_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice, s = x + y + cin.
// Latency: combinational; backpressure: none (pure logic).
module cla4_slice
    import cla_serial_subtractor_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    assign g = x & y;
    assign p = x ^ y;

    // Every internal carry is formed directly from g/p/cin, none ripples.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];

endmodule

// File: rtl/cla_serial_subtractor.sv
// Serial subtractor diff = a - b, one 4-bit CLA slice per cycle (a + ~b + 1).
// Latency: out_valid NSLICE edges after capture; result held until out_ready, in_ready low while busy.
module cla_serial_subtractor
    import cla_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $error("cla_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      idx;
    logic               carry_q;

    logic [SLICE_W-1:0] x_nib;
    logic [SLICE_W-1:0] y_nib;
    logic [SLICE_W-1:0] s_nib;
    logic               cout;

    assign x_nib = a_q[int'(idx)*SLICE_W +: SLICE_W];
    assign y_nib = ~b_q[int'(idx)*SLICE_W +: SLICE_W];

    cla4_slice u_slice (
        .x    (x_nib),
        .y    (y_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            idx       <= '0;
            carry_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        idx      <= '0;
                        carry_q  <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff[int'(idx)*SLICE_W +: SLICE_W] <= s_nib;
                    carry_q <= cout;
                    idx     <= idx + 1'b1;
                    if (idx == LAST) begin
                        // s_nib[MSB] is the final diff sign bit being written this edge.
                        borrow    <= ~cout;
                        overflow  <= (a_q[WIDTH-1] != b_q[WIDTH-1])
                                  && (s_nib[SLICE_W-1] != a_q[WIDTH-1]);
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Directed bench for cla_serial_subtractor with an arithmetic reference model and per-cycle compare.
module tb_cla_serial_subtractor;

    localparam int W      = 16;
    localparam int NSLICE = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    cla_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: transaction-level view of the handshake and plain arithmetic.
    int           cyc = 0;
    int           cap_cyc = 0;
    bit           busy = 0;
    bit           exp_ov = 0;
    logic [W-1:0] exp_diff = '0;
    bit           exp_borrow = 0;
    bit           exp_ovf = 0;
    bit           chk_en = 0;

    always @(posedge clk) begin
        int r;
        cyc++;
        if (rst) begin
            busy   = 0;
            exp_ov = 0;
        end else begin
            if (busy && exp_ov && out_ready) begin
                busy = 0;
            end else if (!busy && in_valid) begin
                busy       = 1;
                cap_cyc    = cyc;
                exp_diff   = a - b;
                exp_borrow = (a < b);
                r          = int'($signed(a)) - int'($signed(b));
                exp_ovf    = (r > 32767) || (r < -32768);
            end
            exp_ov = busy && (cyc >= cap_cyc + NSLICE);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_in_ready", 32'(in_ready), 32'(!busy));
            chk("cyc_out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                chk("cyc_diff", 32'(diff), 32'(exp_diff));
                chk("cyc_borrow", 32'(borrow), 32'(exp_borrow));
                chk("cyc_overflow", 32'(overflow), 32'(exp_ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
        int n;
        out_ready = 1'b1;
        a         = ta;
        b         = tb_v;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out_valid(n);
        chk("latency", 32'(n), 32'(NSLICE));
        chk("lit_diff", 32'(diff), 32'(ed));
        chk("lit_borrow", 32'(borrow), 32'(eb));
        chk("lit_overflow", 32'(overflow), 32'(eo));
        tick();
        chk("pop_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        do_op(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
        do_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        do_op(16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
        do_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);

        // Backpressure with operand pulses during RUN and DONE.
        out_ready = 1'b0;
        a         = 16'h0003;
        b         = 16'h0005;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 16'hFFFF;
        b        = 16'h0000;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out_valid(n);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            tick();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_diff", 32'(diff), 32'h0000FFFE);
            chk("bp_borrow", 32'(borrow), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset during the second RUN cycle.
        a        = 16'h1234;
        b        = 16'h0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        rst = 1'b0;
        do_op(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0);

        // Borrow across all slice boundaries, then an immediate follow-on op.
        do_op(16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0);
        do_op(16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
